// File: rtl/vm_cfg_pkg.sv
// vm_cfg_pkg: shared FSM states, register map and item-word layout for the vending-machine config bus
package vm_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [14:0] MAIN_CFG_ADDR  = 15'h0000;
  localparam logic [14:0] ITEM_BASE_ADDR = 15'h0004;
  localparam int          ITEM_STRIDE    = 4;

  localparam int PRICE_LSB = 0;
  localparam int PRICE_MSB = 15;
  localparam int AVAIL_LSB = 16;
  localparam int AVAIL_MSB = 23;
  localparam int DISP_LSB  = 24;
  localparam int DISP_MSB  = 31;

  // Byte address of item n's config word
  function automatic logic [14:0] item_addr(input int unsigned n);
    return ITEM_BASE_ADDR + 15'(n * ITEM_STRIDE);
  endfunction

endpackage

// File: rtl/vm_cfg_apb_master_if.sv
// vm_cfg_apb_master_if: command, response and APB signals of the config requester
interface vm_cfg_apb_master_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  cfg_mode;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata, cfg_mode
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata, cfg_mode
  );

endinterface

// File: rtl/vm_cfg_apb_master.sv
// vm_cfg_apb_master: single-beat APB requester for config traffic; VM_APB_TIMEOUT_EN adds an ACCESS-phase timeout
module vm_cfg_apb_master
  import vm_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                 pclk,
  input logic                 prstn,
  vm_cfg_apb_master_if.master bus
);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] paddr_nx;
  logic [DATA_WIDTH-1:0] pwdata_nx, rsp_rdata_nx;
  logic                  pwrite_nx, psel_nx, penable_nx, cfg_mode_nx, rsp_valid_nx, rsp_err_nx;
  logic                  timeout;

`ifdef VM_APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  // Count ACCESS cycles without pready, restarting at every SETUP
  always_ff @(posedge pclk or negedge prstn)
    if (!prstn) tcnt <= '0;
    else if (state == SETUP) tcnt <= '0;
    else if (state == ACCESS && !bus.pready) tcnt <= tcnt + 1'b1;
  assign timeout = state == ACCESS && !bus.pready && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  assign bus.cmd_ready = state == IDLE;

  // Next state and next values of every registered output
  always_comb begin
    state_nx     = state;
    paddr_nx     = bus.paddr;
    pwdata_nx    = bus.pwdata;
    pwrite_nx    = bus.pwrite;
    psel_nx      = 1'b0;
    penable_nx   = 1'b0;
    cfg_mode_nx  = 1'b0;
    rsp_valid_nx = bus.rsp_valid;
    rsp_rdata_nx = bus.rsp_rdata;
    rsp_err_nx   = bus.rsp_err;
    case (state)
      IDLE:
        if (bus.cmd_valid) begin
          paddr_nx  = bus.cmd_addr;
          pwdata_nx = bus.cmd_wdata;
          pwrite_nx = bus.cmd_write;
          if (bus.cmd_addr[1:0] != 2'b00) begin
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_err_nx   = 1'b1;
            rsp_rdata_nx = '0;
          end else begin
            state_nx    = SETUP;
            psel_nx     = 1'b1;
            cfg_mode_nx = 1'b1;
          end
        end
      SETUP: begin
        state_nx    = ACCESS;
        psel_nx     = 1'b1;
        penable_nx  = 1'b1;
        cfg_mode_nx = 1'b1;
      end
      ACCESS:
        if (bus.pready || timeout) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = !bus.pready;
          rsp_rdata_nx = (bus.pready && !bus.pwrite) ? bus.prdata : '0;
        end else begin
          psel_nx     = 1'b1;
          penable_nx  = 1'b1;
          cfg_mode_nx = 1'b1;
        end
      RESP:
        if (bus.rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
        end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset drops the bus immediately
  always_ff @(posedge pclk or negedge prstn)
    if (!prstn) begin
      state         <= IDLE;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.pwrite    <= 1'b0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.cfg_mode  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.paddr     <= paddr_nx;
      bus.pwdata    <= pwdata_nx;
      bus.pwrite    <= pwrite_nx;
      bus.psel      <= psel_nx;
      bus.penable   <= penable_nx;
      bus.cfg_mode  <= cfg_mode_nx;
      bus.rsp_valid <= rsp_valid_nx;
      bus.rsp_rdata <= rsp_rdata_nx;
      bus.rsp_err   <= rsp_err_nx;
    end

endmodule
